memif_fb_reader: RTL and testbench
==================================

// Module: memif_fb_reader
// PURPOSE
//   Read DMA for one MCB user port (p0). On each vsync rising edge, issues MCB read commands linearly
//   across the framebuffer, pops the port read FIFO, streams 64-bit words on pix_read (valid/ready).
//   Sits between memif's MCB port and the pixel pipeline, on the initiator side of the port.
// PARAMETERS
//   FB_BASE    30'h0000_0000  byte address of word 0 of the frame; 8-byte aligned
//   FB_WORDS   30000          64-bit words per frame; >=1
//   BURST_LEN  32             words per read command, 1..64
//   RD_DEPTH   64             MCB read-FIFO capacity in words (credit limit)
// PORTS
//   clk_mif         in   1   memif user clock; sole clock
//   sys_rst_n       in   1   asynchronous active-low reset
//   calib_done      in   1   MCB calibration complete
//   vsync           in   1   frame start, synchronous to clk_mif; rising edge used
//   cmd_en          out  1   MCB cmd strobe
//   cmd_instr       out  3   MCB instruction; always 3'b001 (read)
//   cmd_bl          out  6   burst length minus one
//   cmd_byte_addr   out  30  burst start byte address
//   cmd_full        in   1   MCB cmd FIFO full
//   rd_en           out  1   MCB read FIFO pop
//   rd_data         in   64  MCB read data (first-word fall-through)
//   rd_empty        in   1   MCB read FIFO empty
//   rd_count        in   7   MCB read FIFO occupancy (status only)
//   pix_read        out  64  pixel word
//   pix_read_valid  out  1   pix_read holds a word
//   pix_read_ready  in   1   consumer accepts
//   frame_done      out  1   1-cycle pulse when last word of frame is accepted
// BEHAVIOUR
// - Reset: cmd_en=0, cmd_bl=0, cmd_byte_addr=FB_BASE, rd_en=0, pix_read=0, pix_read_valid=0,
//   frame_done=0; state IDLE; counters 0. cmd_instr is constant 3'b001.
// - States: IDLE -> (calib_done & vsync rise) -> RUN -> (all FB_WORDS accepted) -> DONE;
//   DONE -> (vsync rise) -> RUN; RUN -> (vsync rise) -> FLUSH -> (outstanding==0 & skid empty) -> RUN.
//   vsync ignored while calib_done=0 and while in FLUSH.
// - Command issue (RUN only): cmd_en=1 for one cycle when words_left>0, !cmd_full, and
//   outstanding+bl_next <= RD_DEPTH. bl_next = min(BURST_LEN, words_left); cmd_bl=bl_next-1.
//   cmd_byte_addr, cmd_bl valid in the cmd_en cycle; addr advances by bl_next*8 after issue.
//   Never issue while cmd_full=1. Address never wraps within a frame; next frame restarts at FB_BASE.
// - outstanding = words commanded minus words popped (rd_en); issue and pop in the same cycle both
//   apply. Must never exceed RD_DEPTH.
// - Data path: rd_en = !rd_empty & skid_buf can accept. Popped words enter a 2-entry skid buffer driving
//   pix_read/pix_read_valid; transfer on valid&ready. Throughput 1 word/clk with ready held high;
//   latency rd_empty falling -> pix_read_valid = 1 clock. Word order = address order.
// - pix_read/pix_read_valid registered; pix_read stable while valid&!ready.
// - frame_done pulses on the cycle the FB_WORDS-th word is accepted.
// - FLUSH: on vsync rise mid-frame, stop issuing immediately, clear skid buffer (pix_read_valid=0 next
//   cycle), keep popping rd FIFO and discarding until outstanding==0, then reload addr=FB_BASE,
//   words_left=FB_WORDS and enter RUN. Discarded words never appear on pix_read.
// - vsync rise same cycle as last-word accept: frame_done pulses, then normal restart from DONE.
// - calib_done falling: no effect on state (MCB stays in reset-held domain).
// STRUCTURE
// - Package mif_pkg: MIG_CMD_WR=3'b000, MIG_CMD_RD=3'b001, MIG_CMD_WR_AP=3'b010,
//   MIG_CMD_RD_AP=3'b011, MIG_WORD_BYTES=8, MIG_RD_DEPTH=64; state enum typedef.
// - One sub-module: skid_buf (2-entry, WIDTH param, valid/ready both sides, sync clear).
// TESTING (MCB port behavioral model returning addr-tagged data, random 0-20 clk read latency)
// 1. calib_done=0, 3 vsync pulses -> cmd_en never 1; all outputs at reset values.
// 2. FB_WORDS=100, BURST_LEN=32, ready=1 -> cmds addr 0,256,512,768 with bl 31,31,31,3; 100 words in
//    order; exactly one frame_done.
// 3. ready=0 for 200 clks after start -> max 2 cmds (64 words) issued; outstanding<=64; no loss after release.
// 4. cmd_full=1 for 50 clks mid-frame -> cmd_en stays 0; resumes at next address, no skip/duplicate.
// 5. vsync rise after 40 words accepted -> no cmd until outstanding==0; stale words never on pix_read;
//    next accepted word tagged FB_BASE word 0.
// 6. vsync rise coincident with word 99 accept -> frame_done pulse that cycle; next frame starts at FB_BASE.

Source files
------------

// File: rtl/mif_pkg.sv
// Shared MCB user-port definitions: command encodings, port geometry and
// the framebuffer reader state type.
package mif_pkg;

    localparam logic [2:0] MIG_CMD_WR    = 3'b000;
    localparam logic [2:0] MIG_CMD_RD    = 3'b001;
    localparam logic [2:0] MIG_CMD_WR_AP = 3'b010;
    localparam logic [2:0] MIG_CMD_RD_AP = 3'b011;

    localparam int MIG_WORD_BYTES = 8;
    localparam int MIG_RD_DEPTH   = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_t;

endpackage

// File: rtl/memif_fb_reader_skid_buf.sv
// Two-entry skid buffer with registered outputs; i_clear drops both entries
// and wins over any word presented in the same cycle.
module skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             w_out_free;

    assign w_out_free = !r_out_valid || i_ready;
    assign o_ready    = !r_skid_valid;
    assign o_data     = r_out_data;
    assign o_valid    = r_out_valid;
    assign o_empty    = !r_out_valid && !r_skid_valid;

    // o_ready only depends on the skid slot, so the upstream never sees a
    // combinational path from i_ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_data   <= '0;
            r_skid_data  <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_clear) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= i_valid;
                if (i_valid) begin
                    r_out_data <= i_data;
                end
            end
        end else if (i_valid && !r_skid_valid) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/memif_fb_reader.sv
// Framebuffer read DMA on one MCB user port: issues credit-limited read bursts
// on each frame start and streams the returned words through a skid buffer.
module memif_fb_reader
    import mif_pkg::*;
#(
    parameter logic [29:0] FB_BASE   = 30'h0000_0000,
    parameter int          FB_WORDS  = 30000,
    parameter int          BURST_LEN = 32,
    parameter int          RD_DEPTH  = MIG_RD_DEPTH
) (
    input  logic        clk_mif,
    input  logic        sys_rst_n,
    input  logic        calib_done,
    input  logic        vsync,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        rd_en,
    input  logic [63:0] rd_data,
    input  logic        rd_empty,
    input  logic [6:0]  rd_count,
    output logic [63:0] pix_read,
    output logic        pix_read_valid,
    input  logic        pix_read_ready,
    output logic        frame_done
);

    localparam int OW = $clog2(RD_DEPTH + BURST_LEN + 1);

    fb_state_t   r_state;
    fb_state_t   w_state_next;
    logic        r_vsync_d;
    logic [29:0] r_addr;
    logic [31:0] r_words_left;
    logic [31:0] r_accepted;
    logic [OW-1:0] r_outstanding;

    logic [OW-1:0] w_bl_next;
    logic        w_vsync_rise;
    logic        w_credit_ok;
    logic        w_issue;
    logic        w_rd_en;
    logic        w_skid_ready;
    logic        w_skid_empty;
    logic        w_skid_in_valid;
    logic        w_pix_valid;
    logic        w_accept;
    logic        w_last;
    logic        w_reload;
    logic        w_clear;
    logic        w_unused_rd_count;

    assign w_unused_rd_count = ^rd_count;

    // Frame starts are only honoured once the memory is calibrated.
    assign w_vsync_rise = vsync && !r_vsync_d && calib_done;

    always_comb begin
        w_bl_next = OW'(BURST_LEN);
        if (r_words_left < 32'(BURST_LEN)) begin
            w_bl_next = OW'(r_words_left);
        end
    end

    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_bl_next}) <= (OW+1)'(RD_DEPTH);
    assign w_issue     = (r_state == ST_RUN) && !w_vsync_rise && (r_words_left != 32'd0)
                         && !cmd_full && w_credit_ok;

    // In FLUSH the read FIFO is drained without feeding the skid buffer.
    always_comb begin
        w_rd_en = 1'b0;
        if (r_state == ST_RUN) begin
            w_rd_en = !rd_empty && w_skid_ready;
        end else if (r_state == ST_FLUSH) begin
            w_rd_en = !rd_empty && (r_outstanding != '0);
        end
    end

    assign w_skid_in_valid = w_rd_en && (r_state == ST_RUN);
    assign w_accept        = w_pix_valid && pix_read_ready;
    assign w_last          = (r_state == ST_RUN) && w_accept
                             && (r_accepted == 32'(FB_WORDS - 1));

    always_comb begin
        w_state_next = r_state;
        w_reload     = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_vsync_rise) begin
                    w_state_next = ST_RUN;
                    w_reload     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    // Nothing is in flight after the final word, so a coincident
                    // frame start restarts directly.
                    if (w_vsync_rise) begin
                        w_state_next = ST_RUN;
                        w_reload     = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else if (w_vsync_rise) begin
                    w_state_next = ST_FLUSH;
                    w_clear      = 1'b1;
                end
            end
            ST_FLUSH: begin
                if ((r_outstanding == '0) && w_skid_empty) begin
                    w_state_next = ST_RUN;
                    w_reload     = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mif or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_vsync_d     <= 1'b0;
            r_addr        <= FB_BASE;
            r_words_left  <= '0;
            r_accepted    <= '0;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_vsync_d     <= vsync;
            r_outstanding <= r_outstanding + (w_issue ? w_bl_next : '0)
                             - (w_rd_en ? OW'(1) : '0);
            if (w_reload) begin
                r_addr       <= FB_BASE;
                r_words_left <= 32'(FB_WORDS);
                r_accepted   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + 30'(w_bl_next) * 30'(MIG_WORD_BYTES);
                    r_words_left <= r_words_left - 32'(w_bl_next);
                end
                if (w_accept && (r_state == ST_RUN)) begin
                    r_accepted <= r_accepted + 32'd1;
                end
            end
        end
    end

    skid_buf #(
        .WIDTH (64)
    ) u_skid (
        .i_clk   (clk_mif),
        .i_rst_n (sys_rst_n),
        .i_clear (w_clear),
        .i_data  (rd_data),
        .i_valid (w_skid_in_valid),
        .o_ready (w_skid_ready),
        .o_data  (pix_read),
        .o_valid (w_pix_valid),
        .i_ready (pix_read_ready),
        .o_empty (w_skid_empty)
    );

    assign cmd_en         = w_issue;
    assign cmd_instr      = MIG_CMD_RD;
    assign cmd_bl         = (w_bl_next == '0) ? 6'd0 : 6'(w_bl_next - OW'(1));
    assign cmd_byte_addr  = r_addr;
    assign rd_en          = w_rd_en;
    assign pix_read_valid = w_pix_valid;
    assign frame_done     = w_last;

endmodule

// File: tb/tb_memif_fb_reader.sv
// Directed bench for memif_fb_reader against an MCB port model that returns
// words tagged with their word address after a random 0-20 clock latency.
module tb_memif_fb_reader;

    logic        clk_mif = 1'b0;
    logic        sys_rst_n;
    logic        calib_done;
    logic        vsync;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_empty;
    logic [6:0]  rd_count;
    logic [63:0] pix_read;
    logic        pix_read_valid;
    logic        pix_read_ready;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk_mif = ~clk_mif;

    memif_fb_reader #(
        .FB_BASE   (30'h0000_0000),
        .FB_WORDS  (100),
        .BURST_LEN (32),
        .RD_DEPTH  (64)
    ) dut (
        .clk_mif        (clk_mif),
        .sys_rst_n      (sys_rst_n),
        .calib_done     (calib_done),
        .vsync          (vsync),
        .cmd_en         (cmd_en),
        .cmd_instr      (cmd_instr),
        .cmd_bl         (cmd_bl),
        .cmd_byte_addr  (cmd_byte_addr),
        .cmd_full       (cmd_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_count       (rd_count),
        .pix_read       (pix_read),
        .pix_read_valid (pix_read_valid),
        .pix_read_ready (pix_read_ready),
        .frame_done     (frame_done)
    );

    // ---------------- MCB port model ----------------
    logic [31:0] cyc;
    logic [29:0] p_word [0:4095];
    logic [31:0] p_due  [0:4095];
    logic [11:0] p_wr, p_rd;
    logic [63:0] fifo_mem [0:127];
    logic [7:0]  f_wr, f_rd;
    int          ovf_cnt, unf_cnt;

    assign rd_empty = (f_wr == f_rd);
    assign rd_count = 7'(f_wr - f_rd);
    assign rd_data  = fifo_mem[f_rd[6:0]];

    always @(posedge clk_mif or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc <= '0; p_wr <= '0; p_rd <= '0; f_wr <= '0; f_rd <= '0;
            ovf_cnt <= 0; unf_cnt <= 0;
        end else begin
            cyc <= cyc + 32'd1;
            if (cmd_en) begin
                for (int i = 0; i < 64; i++) begin
                    if (i <= int'(cmd_bl)) begin
                        p_word[p_wr + 12'(i)] <= (cmd_byte_addr >> 3) + 30'(i);
                        p_due[p_wr + 12'(i)]  <= cyc + $urandom_range(0, 20);
                    end
                end
                p_wr <= p_wr + 12'(cmd_bl) + 12'd1;
            end
            if ((p_rd != p_wr) && (p_due[p_rd] <= cyc)) begin
                fifo_mem[f_wr[6:0]] <= {34'h0, p_word[p_rd]};
                f_wr <= f_wr + 8'd1;
                p_rd <= p_rd + 12'd1;
                if ((8'(f_wr - f_rd) >= 8'd64) && !rd_en) ovf_cnt <= ovf_cnt + 1;
            end
            if (rd_en) begin
                if (f_wr == f_rd) unf_cnt <= unf_cnt + 1;
                else              f_rd <= f_rd + 8'd1;
            end
        end
    end

    // ---------------- Monitor ----------------
    logic [29:0] cmd_addr_log [0:255];
    logic [5:0]  cmd_bl_log   [0:255];
    logic [31:0] cmd_out_log  [0:255];
    logic [7:0]  cmd_n;
    logic [29:0] acc_log [0:1023];
    logic [9:0]  acc_n;
    logic [31:0] m_out, max_out;
    int          fd_n, full_viol;
    logic [9:0]  fd_at;

    always @(posedge clk_mif or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_n <= '0; acc_n <= '0; m_out <= '0; max_out <= '0;
            fd_n <= 0; fd_at <= '0; full_viol <= 0;
        end else begin
            if (cmd_en) begin
                cmd_addr_log[cmd_n] <= cmd_byte_addr;
                cmd_bl_log[cmd_n]   <= cmd_bl;
                cmd_out_log[cmd_n]  <= m_out;
                cmd_n <= cmd_n + 8'd1;
                if (cmd_full) full_viol <= full_viol + 1;
                $display("t=%0t cmd addr=%0d bl=%0d outstanding=%0d", $time, cmd_byte_addr, cmd_bl, m_out);
            end
            m_out <= m_out + (cmd_en ? 32'(cmd_bl) + 32'd1 : 32'd0) - (rd_en ? 32'd1 : 32'd0);
            if (m_out > max_out) max_out <= m_out;
            if (pix_read_valid && pix_read_ready) begin
                acc_log[acc_n] <= pix_read[29:0];
                acc_n <= acc_n + 10'd1;
            end
            if (frame_done) begin
                fd_n  <= fd_n + 1;
                fd_at <= acc_n + ((pix_read_valid && pix_read_ready) ? 10'd1 : 10'd0);
                $display("t=%0t frame_done after %0d words", $time, acc_n + 10'd1);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic do_reset();
        sys_rst_n = 1'b0; calib_done = 1'b0; vsync = 1'b0;
        cmd_full = 1'b0; pix_read_ready = 1'b0;
        repeat (3) @(negedge clk_mif);
        sys_rst_n = 1'b1;
        @(negedge clk_mif);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        @(negedge clk_mif);
        vsync = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(acc_n) >= n) begin ok = 1'b1; break; end
            @(negedge clk_mif);
        end
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fd_n >= n) begin ok = 1'b1; break; end
            @(negedge clk_mif);
        end
        repeat (4) @(negedge clk_mif);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        sys_rst_n = 1'b0; calib_done = 1'b0; vsync = 1'b0;
        cmd_full = 1'b0; pix_read_ready = 1'b1;
        repeat (2) @(negedge clk_mif);
        checks++; if (cmd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_en: got %b want 0", cmd_en); end
        checks++; if (cmd_instr !== 3'b001) begin errors++; $display("FAIL reset_cmd_instr: got %b want 001", cmd_instr); end
        checks++; if (cmd_bl !== 6'd0) begin errors++; $display("FAIL reset_cmd_bl: got %0d want 0", cmd_bl); end
        checks++; if (cmd_byte_addr !== 30'd0) begin errors++; $display("FAIL reset_cmd_addr: got %0h want 0", cmd_byte_addr); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (pix_read !== 64'd0) begin errors++; $display("FAIL reset_pix_read: got %h want 0", pix_read); end
        checks++; if (pix_read_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", pix_read_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        sys_rst_n = 1'b1;
        @(negedge clk_mif);
    endtask

    task automatic test_no_calib();
        do_reset();
        pix_read_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_vsync();
            repeat (20) @(negedge clk_mif);
        end
        checks++; if (cmd_n !== 8'd0) begin errors++; $display("FAIL nocal_cmds: got %0d commands want 0", cmd_n); end
        checks++; if (pix_read_valid !== 1'b0) begin errors++; $display("FAIL nocal_valid: got %b want 0", pix_read_valid); end
        checks++; if (cmd_byte_addr !== 30'd0) begin errors++; $display("FAIL nocal_addr: got %0h want 0", cmd_byte_addr); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL nocal_rd_en: got %b want 0", rd_en); end
    endtask

    task automatic test_frame();
        logic [29:0] exp_addr [4] = '{30'd0, 30'd256, 30'd512, 30'd768};
        logic [5:0]  exp_bl   [4] = '{6'd31, 6'd31, 6'd31, 6'd3};
        bit ok; int bad; int first_bad;
        do_reset();
        calib_done = 1'b1; pix_read_ready = 1'b1;
        pulse_vsync();
        wait_fd(1, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: frame_done count %0d want 1", fd_n); end
        checks++; if (cmd_n !== 8'd4) begin errors++; $display("FAIL frame_cmd_count: got %0d want 4", cmd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL frame_cmd_addr[%0d]: got %0d want %0d", i, cmd_addr_log[i], exp_addr[i]); end
            checks++; if (cmd_bl_log[i] !== exp_bl[i]) begin errors++; $display("FAIL frame_cmd_bl[%0d]: got %0d want %0d", i, cmd_bl_log[i], exp_bl[i]); end
        end
        checks++; if (acc_n !== 10'd100) begin errors++; $display("FAIL frame_words: got %0d want 100", acc_n); end
        bad = 0; first_bad = -1;
        for (int i = 0; i < 100; i++)
            if (acc_log[i] !== 30'(i)) begin bad++; if (first_bad < 0) first_bad = i; end
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_order: %0d words wrong, first index %0d, want 0 wrong", bad, first_bad); end
        checks++; if (fd_n !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_n); end
        checks++; if (fd_at !== 10'd100) begin errors++; $display("FAIL frame_done_cycle: pulsed at word %0d want 100", fd_at); end
        checks++; if (ovf_cnt + unf_cnt + full_viol !== 0) begin errors++; $display("FAIL frame_port_protocol: ovf %0d unf %0d full %0d want 0", ovf_cnt, unf_cnt, full_viol); end
    endtask

    task automatic test_backpressure();
        bit ok; int bad;
        do_reset();
        calib_done = 1'b1; pix_read_ready = 1'b0;
        pulse_vsync();
        repeat (200) @(negedge clk_mif);
        checks++; if (cmd_n !== 8'd2) begin errors++; $display("FAIL bp_cmd_count: got %0d want 2", cmd_n); end
        checks++; if (max_out > 32'd64) begin errors++; $display("FAIL bp_outstanding: max %0d want <=64", max_out); end
        checks++; if (rd_count !== 7'd62) begin errors++; $display("FAIL bp_fifo_level: got %0d want 62", rd_count); end
        checks++; if (pix_read_valid !== 1'b1 || pix_read[29:0] !== 30'd0) begin errors++; $display("FAIL bp_hold: valid %b word %0d want valid 1 word 0", pix_read_valid, pix_read[29:0]); end
        pix_read_ready = 1'b1;
        wait_fd(1, 3000, ok);
        checks++; if (!ok || acc_n !== 10'd100) begin errors++; $display("FAIL bp_release: got %0d words want 100", acc_n); end
        bad = 0;
        for (int i = 0; i < 100; i++) if (acc_log[i] !== 30'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: %0d words wrong want 0", bad); end
        checks++; if (ovf_cnt !== 0) begin errors++; $display("FAIL bp_overflow: got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_cmd_full();
        bit ok; int bad;
        do_reset();
        calib_done = 1'b1; pix_read_ready = 1'b1;
        pulse_vsync();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_n >= 8'd1) begin ok = 1'b1; break; end
            @(negedge clk_mif);
        end
        cmd_full = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL full_first_cmd: got %0d commands want 1", cmd_n); end
        repeat (50) @(negedge clk_mif);
        checks++; if (cmd_n !== 8'd1) begin errors++; $display("FAIL full_blocked: got %0d commands want 1", cmd_n); end
        cmd_full = 1'b0;
        wait_fd(1, 3000, ok);
        checks++; if (full_viol !== 0) begin errors++; $display("FAIL full_violation: got %0d cmds under full want 0", full_viol); end
        checks++; if (cmd_n !== 8'd4) begin errors++; $display("FAIL full_cmd_count: got %0d want 4", cmd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_addr_log[i] !== 30'(i * 256)) begin errors++; $display("FAIL full_cmd_addr[%0d]: got %0d want %0d", i, cmd_addr_log[i], i * 256); end
        end
        bad = 0;
        for (int i = 0; i < 100; i++) if (acc_log[i] !== 30'(i)) bad++;
        checks++; if (!ok || acc_n !== 10'd100 || bad != 0) begin errors++; $display("FAIL full_stream: %0d words, %0d wrong, want 100 and 0", acc_n, bad); end
    endtask

    task automatic test_flush();
        bit ok; int k; int bad; int c;
        do_reset();
        calib_done = 1'b1; pix_read_ready = 1'b1;
        pulse_vsync();
        wait_acc(40, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_wait40: got %0d words want 40", acc_n); end
        pulse_vsync();
        checks++; if (pix_read_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: valid %b want 0", pix_read_valid); end
        wait_fd(1, 4000, ok);
        k = -1;
        for (int i = 40; i < 42; i++) if (k < 0 && acc_log[i] === 30'd0) k = i;
        checks++; if (k < 0) begin errors++; $display("FAIL flush_restart_word: words %0d,%0d want a word 0 at index 40 or 41", acc_log[40], acc_log[41]); end
        if (k < 0) k = 41;
        bad = 0;
        for (int i = 0; i < k; i++) if (acc_log[i] !== 30'(i)) bad++;
        for (int j = 0; j < 100; j++) if (acc_log[k + j] !== 30'(j)) bad++;
        checks++; if (!ok || int'(acc_n) != k + 100 || bad != 0) begin errors++; $display("FAIL flush_stream: %0d words, %0d wrong, want %0d and 0", acc_n, bad, k + 100); end
        c = -1;
        for (int i = 1; i < int'(cmd_n); i++) if (c < 0 && cmd_addr_log[i] === 30'd0) c = i;
        checks++; if (c < 0 || cmd_out_log[c] !== 32'd0) begin errors++; $display("FAIL flush_cmd_gate: restart cmd %0d saw outstanding %0d want 0", c, (c < 0) ? 32'hFFFF_FFFF : cmd_out_log[c]); end
        checks++; if (fd_n !== 1 || int'(fd_at) != k + 100) begin errors++; $display("FAIL flush_frame_done: count %0d at %0d want 1 at %0d", fd_n, fd_at, k + 100); end
        checks++; if (max_out > 32'd64 || ovf_cnt !== 0) begin errors++; $display("FAIL flush_credit: max %0d ovf %0d want <=64 and 0", max_out, ovf_cnt); end
    endtask

    task automatic test_coincident();
        bit ok; int bad;
        do_reset();
        calib_done = 1'b1; pix_read_ready = 1'b1;
        pulse_vsync();
        wait_acc(99, 2000, ok);
        pix_read_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL coin_wait99: got %0d words want 99", acc_n); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pix_read_valid) begin ok = 1'b1; break; end
            @(negedge clk_mif);
        end
        checks++; if (!ok) begin errors++; $display("FAIL coin_word99_valid: valid %b want 1", pix_read_valid); end
        pix_read_ready = 1'b1;
        vsync = 1'b1;
        @(negedge clk_mif);
        vsync = 1'b0;
        checks++; if (fd_n !== 1 || fd_at !== 10'd100) begin errors++; $display("FAIL coin_frame_done: count %0d at %0d want 1 at 100", fd_n, fd_at); end
        wait_fd(2, 3000, ok);
        checks++; if (!ok || acc_n !== 10'd200) begin errors++; $display("FAIL coin_second_frame: got %0d words want 200", acc_n); end
        checks++; if (cmd_n !== 8'd8 || cmd_addr_log[4] !== 30'd0) begin errors++; $display("FAIL coin_restart_cmd: %0d cmds, 5th addr %0d want 8 and 0", cmd_n, cmd_addr_log[4]); end
        bad = 0;
        for (int j = 0; j < 100; j++) if (acc_log[100 + j] !== 30'(j)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL coin_order: %0d words wrong want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_no_calib();
        test_frame();
        test_backpressure();
        test_cmd_full();
        test_flush();
        test_coincident();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
